instr_fetch_unit: RTL

- Fetch stage feeding decode of the LEGv8 datapath; owns the fetch PC.
- Issues word reads to an instruction memory with variable latency over a req/ack handshake.
- Buffers returned instructions and their PCs in a small FIFO.
- Presents them to decode over valid/ready and supports redirect (taken branch / B) with a flush.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 81 ++++++++
 rtl/instr_fetch_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 fetch stage.
// Used by fetch_fifo and instr_fetch_unit.
package fetch_pkg;

    localparam int INSTR_W        = 32;
    localparam int ADDR_W         = 64;
    localparam int DEFAULT_PC_INC = 4;
    localparam int DEFAULT_DEPTH  = 4;

    // One buffered fetch result: the instruction word and the PC it came from.
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // 32-bit add that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO of fetch entries (PC + instruction) between fetch and decode.
// The head is read combinationally. Flush empties the FIFO and overrides push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk_i,
    input  logic               srst_i,
    input  logic               push_i,
    input  fetch_entry_t       push_entry_i,
    input  logic               pop_i,
    input  logic               flush_i,
    output logic [CNT_W-1:0]   count_o,
    output fetch_entry_t       head_o,
    output logic               full_o,
    output logic               empty_o
);

    fetch_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic               do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Pushing into a full FIFO or popping an empty one is ignored.
    assign do_push = push_i && !flush_i && !full_o;
    assign do_pop  = pop_i  && !flush_i && !empty_o;

    // Next-state for the pointers and the occupancy count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage. The contents need no reset because the count gates validity.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// LEGv8 fetch stage. It owns the fetch PC and issues one word read at a time to
// instruction memory over req/ack. It buffers returned words in fetch_fifo and
// presents them to decode over valid/ready. A redirect flushes the buffered work.
// If a read is still in flight at the redirect, that read is marked stale and its
// data is dropped when it returns.
// Optional build macro: FETCH_STATS_EN adds saturating fetch_count/discard_count outputs.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int PC_INC = DEFAULT_PC_INC
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [ADDR_W-1:0]  startPC,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [INSTR_W-1:0] inst_data,
    output logic [ADDR_W-1:0]  inst_pc,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]        fetch_count,
    output logic [31:0]        discard_count
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic              req_q,      req_d;
    logic              stale_q,    stale_d;

    logic              ack;
    logic              fifo_push, fifo_pop;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  cnt_after;
    logic              room;
    fetch_entry_t      push_entry, head_entry;

    // An ack only counts while a request is actually on the bus.
    assign ack = req_q && imem_ack;

    // Stale returns and returns that coincide with a redirect never enter the FIFO.
    assign fifo_push        = ack && !stale_q && !redirect && !fifo_full;
    assign fifo_pop         = inst_valid && inst_ready;
    assign push_entry.pc    = addr_q;
    assign push_entry.instr = imem_rdata;

    // Occupancy after this cycle's push and pop. It decides whether another read may issue.
    assign cnt_after = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    assign room      = (cnt_after < CNT_W'(DEPTH));

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (CLK),
        .srst_i       (Reset),
        .push_i       (fifo_push),
        .push_entry_i (push_entry),
        .pop_i        (fifo_pop),
        .flush_i      (redirect),
        .count_o      (fifo_count),
        .head_o       (head_entry),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

    assign inst_valid = !fifo_empty;
    assign inst_data  = head_entry.instr;
    assign inst_pc    = head_entry.pc;
    assign imem_req   = req_q;
    assign imem_addr  = addr_q;

    // Request and PC sequencing. A pending read is never withdrawn except by Reset.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        req_d      = req_q;
        stale_d    = stale_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            if (req_q && !imem_ack) begin
                // Keep the bus stable and drop the data when it arrives.
                stale_d = 1'b1;
            end else begin
                // Bus is free now (idle or just acked): restart at the target.
                stale_d = 1'b0;
                req_d   = 1'b1;
                addr_d  = redirect_pc;
            end
        end else if (req_q) begin
            if (imem_ack) begin
                stale_d = 1'b0;
                if (!stale_q) begin
                    fetch_pc_d = fetch_pc_q + ADDR_W'(PC_INC);
                end
                req_d  = room;
                addr_d = fetch_pc_d;
            end
        end else begin
            req_d  = room;
            addr_d = fetch_pc_q;
        end
    end

    // Fetch state registers. Reset abandons any in-flight read.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            fetch_pc_q <= startPC;
            addr_q     <= startPC;
            req_q      <= 1'b0;
            stale_q    <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            stale_q    <= stale_d;
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count_q,   fetch_count_d;
    logic [31:0] discard_count_q, discard_count_d;
    logic [31:0] dropped_now;

    // Discards this cycle: a dropped return plus every entry thrown away by a flush.
    always_comb begin
        dropped_now = 32'(ack && (stale_q || redirect));
        if (redirect) begin
            dropped_now = dropped_now + 32'(fifo_count);
        end
        fetch_count_d   = sat_add32(fetch_count_q, 32'(fifo_push));
        discard_count_d = sat_add32(discard_count_q, dropped_now);
    end

    // Statistics registers.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            fetch_count_q   <= '0;
            discard_count_q <= '0;
        end else begin
            fetch_count_q   <= fetch_count_d;
            discard_count_q <= discard_count_d;
        end
    end

    assign fetch_count   = fetch_count_q;
    assign discard_count = discard_count_q;
`endif

endmodule
